// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bus: redirect sources and RAS controls in, fetch PC and RAS view out.
// Latency: none (wires only); the registered stage lives in pc_sequencer.
// Backpressure: no handshake; stall is carried here as a plain level input.
interface pc_sequencer_if;
    logic        stall;
    logic        isCompressed;
    logic [31:0] immediate;
    logic [31:0] rs1Data;
    logic        branchTaken;
    logic        jalEn;
    logic        jalrEn;
    logic        callEn;
    logic        retEn;
    logic        trapEn;
    logic [31:0] trapVector;
    logic        mretEn;
    logic [31:0] mepc;
    logic [31:0] pcIF;
    logic [31:0] pcLink;
    logic        redirect;
    logic [31:0] rasTop;
    logic        rasValid;

    // Master side drives the control inputs and observes the PC and RAS state.
    modport master (
        output stall, isCompressed, immediate, rs1Data, branchTaken, jalEn, jalrEn,
               callEn, retEn, trapEn, trapVector, mretEn, mepc,
        input  pcIF, pcLink, redirect, rasTop, rasValid
    );

    // Slave side is the sequencer itself.
    modport slave (
        input  stall, isCompressed, immediate, rs1Data, branchTaken, jalEn, jalrEn,
               callEn, retEn, trapEn, trapVector, mretEn, mepc,
        output pcIF, pcLink, redirect, rasTop, rasValid
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with prioritised redirects and a circular return-address stack.
// Latency: pcIF and RAS update one clock after inputs are sampled; pcLink/redirect/rasTop are combinational.
// Backpressure: stall holds pcIF unless a redirect source is active; the RAS ignores stall.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          RAS_DEPTH    = 4,
    parameter bit          COMPRESSED   = 1'b1
) (
    input logic           clk,
    input logic           arst,
    pc_sequencer_if.slave bus
);
    localparam int          PTR_W      = $clog2(RAS_DEPTH);
    localparam int          CNT_W      = PTR_W + 1;
    localparam logic [31:0] ALIGN_MASK = COMPRESSED ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

    logic [31:0]      pcReg;
    logic [31:0]      linkAddr;
    logic [31:0]      nextRaw;
    logic [31:0]      nextPc;
    logic             compStep;
    logic             anyRedirect;
    logic             doCall;
    logic             doRet;
    logic [31:0]      rasMem [RAS_DEPTH];
    logic [PTR_W-1:0] topPtr;
    logic [CNT_W-1:0] rasCount;

    // Compressed steps only exist when the build supports them.
    assign compStep    = COMPRESSED && bus.isCompressed;
    assign linkAddr    = pcReg + (compStep ? 32'd2 : 32'd4);
    assign anyRedirect = bus.trapEn | bus.mretEn | bus.jalrEn | bus.jalEn | bus.branchTaken;

    // A trap owns the cycle, so call/return bookkeeping is dropped alongside it.
    assign doCall = bus.callEn & ~bus.trapEn;
    assign doRet  = bus.retEn  & ~bus.trapEn;

    // Next-PC select in fixed priority; redirects beat stall, sequential is the fallback.
    always_comb begin
        nextRaw = linkAddr;
        if (bus.trapEn) begin
            nextRaw = bus.trapVector;
        end else if (bus.mretEn) begin
            nextRaw = bus.mepc;
        end else if (bus.jalrEn) begin
            nextRaw = bus.rs1Data + bus.immediate;
        end else if (bus.jalEn || bus.branchTaken) begin
            nextRaw = pcReg + bus.immediate;
        end else if (bus.stall) begin
            nextRaw = pcReg;
        end
    end

    // Every target is halfword aligned, or word aligned without compressed support.
    assign nextPc = nextRaw & ALIGN_MASK;

    // Fetch PC register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pcReg <= RESET_VECTOR;
        end else begin
            pcReg <= nextPc;
        end
    end

    // Return-address stack: push writes above top, pop retreats, push+pop replaces top.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            topPtr   <= '0;
            rasCount <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                rasMem[i] <= '0;
            end
        end else begin
            if (doCall && doRet && (rasCount != '0)) begin
                rasMem[topPtr] <= linkAddr;
            end else if (doCall) begin
                // When full the pointer simply wraps onto the oldest entry.
                rasMem[PTR_W'(topPtr + 1'b1)] <= linkAddr;
                topPtr <= PTR_W'(topPtr + 1'b1);
                if (rasCount != CNT_W'(RAS_DEPTH)) begin
                    rasCount <= rasCount + 1'b1;
                end
            end else if (doRet && (rasCount != '0)) begin
                topPtr   <= PTR_W'(topPtr - 1'b1);
                rasCount <= rasCount - 1'b1;
            end
        end
    end

    assign bus.pcIF     = pcReg;
    assign bus.pcLink   = linkAddr;
    assign bus.redirect = anyRedirect;
    assign bus.rasTop   = rasMem[topPtr];
    assign bus.rasValid = (rasCount != '0);
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then randomized traffic vs a queue-based model.
// Latency: model advances once per clock, comparing combinational outputs just before each edge.
// Backpressure: stall is driven like any other random input.
module tb_pc_sequencer;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          DEPTH = 4;

    logic clk;
    logic arst;
    int   checks;
    int   errors;

    // Reference state: fetch PC plus the stack as a bounded queue (newest at the back).
    logic [31:0] mPc;
    logic [31:0] mStack [$];
    bit          mEverPushed;
    logic        lastRedirect;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH),
        .COMPRESSED   (1'b1)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        bus.stall = 0; bus.isCompressed = 0; bus.immediate = 0; bus.rs1Data = 0;
        bus.branchTaken = 0; bus.jalEn = 0; bus.jalrEn = 0; bus.callEn = 0; bus.retEn = 0;
        bus.trapEn = 0; bus.trapVector = 0; bus.mretEn = 0; bus.mepc = 0;
    endtask

    task automatic modelReset();
        mPc = RV;
        mStack.delete();
        mEverPushed = 0;
    endtask

    // Compare everything visible against the model, clock once, then advance the model.
    task automatic step();
        logic [31:0] link;
        logic [31:0] nxt;
        logic        red;
        bit          c;
        bit          r;
        #1;
        link = mPc + ((bus.isCompressed === 1'b1) ? 32'd2 : 32'd4);
        red  = bus.trapEn | bus.mretEn | bus.jalrEn | bus.jalEn | bus.branchTaken;
        if (bus.trapEn)                        nxt = bus.trapVector;
        else if (bus.mretEn)                   nxt = bus.mepc;
        else if (bus.jalrEn)                   nxt = bus.rs1Data + bus.immediate;
        else if (bus.jalEn || bus.branchTaken) nxt = mPc + bus.immediate;
        else if (bus.stall)                    nxt = mPc;
        else                                   nxt = link;
        nxt[0] = 1'b0;
        check("pcIF", bus.pcIF, mPc);
        check("pcLink", bus.pcLink, link);
        check("redirect", {31'd0, bus.redirect}, {31'd0, red});
        check("rasValid", {31'd0, bus.rasValid}, {31'd0, mStack.size() > 0});
        if (mStack.size() > 0)  check("rasTop", bus.rasTop, mStack[mStack.size() - 1]);
        else if (!mEverPushed)  check("rasTopClear", bus.rasTop, 32'h0);
        lastRedirect = bus.redirect;
        c = bus.callEn && !bus.trapEn;
        r = bus.retEn && !bus.trapEn;
        @(posedge clk);
        #1;
        mPc = nxt;
        if (c && r && mStack.size() > 0) begin
            mStack[mStack.size() - 1] = link;
        end else if (c) begin
            mStack.push_back(link);
            mEverPushed = 1;
            if (mStack.size() > DEPTH) void'(mStack.pop_front());
        end else if (r && mStack.size() > 0) begin
            void'(mStack.pop_back());
        end
    endtask

    task automatic gotoPc(input logic [31:0] target);
        clearInputs();
        bus.jalrEn = 1; bus.rs1Data = target;
        step();
        clearInputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        arst = 1'b1;
        clearInputs();
        modelReset();

        // Reset state holds without any clock edge mattering.
        #12;
        check("resetPc", bus.pcIF, RV);
        check("resetRasValid", {31'd0, bus.rasValid}, 32'd0);
        check("resetRasTop", bus.rasTop, 32'h0);
        @(posedge clk);
        #1;
        arst = 1'b0;

        // Free-running with sizes 4,2,4.
        bus.isCompressed = 0; step(); check("seq0", bus.pcIF, 32'h4);
        bus.isCompressed = 1; step(); check("seq1", bus.pcIF, 32'h6);
        bus.isCompressed = 0; step(); check("seq2", bus.pcIF, 32'hA);

        // Branch overrides stall; stall alone holds.
        gotoPc(32'h100);
        bus.stall = 1; bus.branchTaken = 1; bus.immediate = 32'hFFFF_FFF0;
        step();
        check("brOverStall", bus.pcIF, 32'h0F0);
        check("brRedirect", {31'd0, lastRedirect}, 32'd1);
        clearInputs();
        bus.stall = 1;
        step();
        check("stallHold", bus.pcIF, 32'h0F0);

        // Trap wins over JALR; JALR alone clears bit0.
        gotoPc(32'h200);
        bus.jalrEn = 1; bus.rs1Data = 32'h1001; bus.immediate = 32'h4;
        bus.trapEn = 1; bus.trapVector = 32'h8000_0000;
        step();
        check("trapWins", bus.pcIF, 32'h8000_0000);
        gotoPc(32'h200);
        bus.jalrEn = 1; bus.rs1Data = 32'h1001; bus.immediate = 32'h4;
        step();
        check("jalrAlign", bus.pcIF, 32'h1004);

        // Five calls into a four-deep stack, then drain past empty.
        gotoPc(32'h0C);
        for (int k = 1; k <= 5; k++) begin
            bus.callEn = 1; bus.jalrEn = 1; bus.rs1Data = 32'h10 * (k + 1) - 32'h4;
            step();
        end
        clearInputs();
        check("rasFullTop", bus.rasTop, 32'h50);
        check("rasFullValid", {31'd0, bus.rasValid}, 32'd1);
        bus.stall = 1; bus.retEn = 1;
        step(); check("pop1", bus.rasTop, 32'h40);
        step(); check("pop2", bus.rasTop, 32'h30);
        step(); check("pop3", bus.rasTop, 32'h20);
        step(); check("pop4Valid", {31'd0, bus.rasValid}, 32'd0);
        step(); check("pop5Valid", {31'd0, bus.rasValid}, 32'd0);
        clearInputs();

        // Two entries (0x20, 0x30), then call+ret replaces top in place.
        gotoPc(32'h1C);
        bus.callEn = 1; bus.jalrEn = 1; bus.rs1Data = 32'h2C;
        step();
        clearInputs();
        bus.callEn = 1;
        step();
        clearInputs();
        check("twoTop", bus.rasTop, 32'h30);
        gotoPc(32'h96);
        bus.callEn = 1; bus.retEn = 1; bus.stall = 1;
        step();
        clearInputs();
        check("swapTop", bus.rasTop, 32'h9A);
        bus.retEn = 1; bus.stall = 1;
        step();
        clearInputs();
        check("swapCount", bus.rasTop, 32'h20);

        // Sequential wrap at the top of the address space.
        gotoPc(32'hFFFF_FFFC);
        step();
        check("pcWrap", bus.pcIF, 32'h0);

        // Asynchronous reset mid-cycle with three entries and a pending call.
        for (int k = 0; k < 2; k++) begin
            bus.callEn = 1;
            step();
        end
        clearInputs();
        check("threeValid", {31'd0, bus.rasValid}, 32'd1);
        bus.callEn = 1; bus.jalEn = 1; bus.immediate = 32'h40;
        #2;
        arst = 1'b1;
        #1;
        check("asyncPc", bus.pcIF, RV);
        check("asyncRasValid", {31'd0, bus.rasValid}, 32'd0);
        check("asyncRasTop", bus.rasTop, 32'h0);
        #1;
        arst = 1'b0;
        clearInputs();
        modelReset();
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bus.stall        = ($urandom_range(0, 3) == 0);
            bus.isCompressed = $urandom_range(0, 1);
            bus.immediate    = $urandom;
            bus.rs1Data      = $urandom;
            bus.branchTaken  = ($urandom_range(0, 7) == 0);
            bus.jalEn        = ($urandom_range(0, 9) == 0);
            bus.jalrEn       = ($urandom_range(0, 9) == 0);
            bus.callEn       = ($urandom_range(0, 3) == 0);
            bus.retEn        = ($urandom_range(0, 3) == 0);
            bus.trapEn       = ($urandom_range(0, 19) == 0);
            bus.trapVector   = $urandom;
            bus.mretEn       = ($urandom_range(0, 14) == 0);
            bus.mepc         = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
